ascon_perm_iter: RTL

ASCON_PERM_ITER -- requirements
Module: ascon_perm_iter

---
 rtl/ascon_perm_iter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: loads five 64-bit words, runs 12/8/6 rounds at
// UNROLL rounds per clock, then streams the five result words back out.
module ascon_perm_iter #(
    parameter int unsigned UNROLL       = 1,
    parameter bit          RST_OUT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [1:0]  rounds_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {StLoad, StPerm, StUnload} state_e;
    typedef logic [4:0][63:0] perm_state_t;

    state_e      state_q, state_d;
    perm_state_t x_q, x_d;
    perm_state_t r1, r2;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [3:0]  ri_q, ri_d;

    function automatic logic [63:0] rotr(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic perm_state_t ascon_round(input perm_state_t s_in, input logic [3:0] k);
        perm_state_t s;
        perm_state_t t;
        s = s_in;
        s[2] = s[2] ^ {56'd0, 4'd15 - k, k};
        s[0] ^= s[4];
        s[4] ^= s[3];
        s[2] ^= s[1];
        t[0] = ~s[0] & s[1];
        t[1] = ~s[1] & s[2];
        t[2] = ~s[2] & s[3];
        t[3] = ~s[3] & s[4];
        t[4] = ~s[4] & s[0];
        s[0] ^= t[1];
        s[1] ^= t[2];
        s[2] ^= t[3];
        s[3] ^= t[4];
        s[4] ^= t[0];
        s[1] ^= s[0];
        s[0] ^= s[4];
        s[3] ^= s[2];
        s[2] = ~s[2];
        s[0] ^= rotr(s[0], 19) ^ rotr(s[0], 28);
        s[1] ^= rotr(s[1], 61) ^ rotr(s[1], 39);
        s[2] ^= rotr(s[2], 1) ^ rotr(s[2], 6);
        s[3] ^= rotr(s[3], 10) ^ rotr(s[3], 17);
        s[4] ^= rotr(s[4], 7) ^ rotr(s[4], 41);
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        wcnt_d  = wcnt_q;
        ri_d    = ri_q;
        r1      = ascon_round(x_q, ri_q);
        // Second round chains combinationally off the first when unrolled.
        r2      = ascon_round(r1, ri_q + 4'd1);

        unique case (state_q)
            StLoad: begin
                if (in_valid) begin
                    x_d[wcnt_q] = in_data;
                    if (wcnt_q == 3'd4) begin
                        wcnt_d  = 3'd0;
                        state_d = StPerm;
                        // Start index is 12 - n so the last round is always index 11.
                        unique case (rounds_sel)
                            2'b01:   ri_d = 4'd4;
                            2'b10:   ri_d = 4'd6;
                            default: ri_d = 4'd0;
                        endcase
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            StPerm: begin
                x_d  = (UNROLL == 2) ? r2 : r1;
                ri_d = ri_q + 4'(UNROLL);
                if (ri_d == 4'd12) state_d = StUnload;
            end
            StUnload: begin
                if (out_ready) begin
                    if (wcnt_q == 3'd4) begin
                        wcnt_d  = 3'd0;
                        state_d = StLoad;
                    end else begin
                        wcnt_d = wcnt_q + 3'd1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StLoad;
            x_q     <= '0;
            wcnt_q  <= 3'd0;
            ri_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            wcnt_q  <= wcnt_d;
            ri_q    <= ri_d;
        end
    end

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StUnload);
    assign busy      = (state_q == StPerm);

    always_comb begin
        out_data = '0;
        if ((out_valid || !RST_OUT_ZERO) && (wcnt_q <= 3'd4)) begin
            out_data = x_q[wcnt_q];
        end
    end

endmodule
